// File: rtl/parking_sensor_conditioner.sv
// Beam-sensor conditioning for the parking entry/exit FSM.
// Each raw beam input is synchronised, debounced by a confirm state machine,
// and watched for an abnormally long blocked period (stuck sensor).
// Rejected glitches from both channels are totalled in a saturating counter.

module parking_sensor_channel #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STUCK_CYCLES    = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic glitch,
    output logic stuck_hit
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(STUCK_CYCLES + 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES);
    localparam logic [HW-1:0] HOLD_MAX = HW'(STUCK_CYCLES);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        CONF_HI   = 2'd1,
        STABLE_HI = 2'd2,
        CONF_LO   = 2'd3
    } deb_state_t;

    logic [1:0]    sync_r;
    deb_state_t    state_r;
    logic [CW-1:0] cnt_r;
    logic          level_r;
    logic [HW-1:0] hold_r;
    logic          s_s;
    logic [CW-1:0] cnt_inc_s;
    logic          glitch_s;
    logic          stuck_hit_s;

    // Synchronised sample, next confirm count, glitch and stuck-threshold events.
    always_comb begin
        s_s         = sync_r[1];
        cnt_inc_s   = cnt_r + CW'(1);
        glitch_s    = ((state_r == CONF_HI) && !s_s) || ((state_r == CONF_LO) && s_s);
        stuck_hit_s = level_r && (hold_r == (HOLD_MAX - HW'(1)));
    end

    // Two-flop synchroniser plus debounce FSM; the clean level is registered with the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r  <= 2'b00;
            state_r <= STABLE_LO;
            cnt_r   <= '0;
            level_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[0], raw};
            case (state_r)
                STABLE_LO: begin
                    if (s_s) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state_r <= STABLE_HI;
                            level_r <= 1'b1;
                            cnt_r   <= '0;
                        end else begin
                            state_r <= CONF_HI;
                            cnt_r   <= CW'(1);
                        end
                    end else begin
                        state_r <= STABLE_LO;
                    end
                end
                CONF_HI: begin
                    if (s_s) begin
                        if (cnt_inc_s == DEB_LAST) begin
                            state_r <= STABLE_HI;
                            level_r <= 1'b1;
                            cnt_r   <= '0;
                        end else begin
                            cnt_r <= cnt_inc_s;
                        end
                    end else begin
                        state_r <= STABLE_LO;
                        cnt_r   <= '0;
                    end
                end
                STABLE_HI: begin
                    if (!s_s) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state_r <= STABLE_LO;
                            level_r <= 1'b0;
                            cnt_r   <= '0;
                        end else begin
                            state_r <= CONF_LO;
                            cnt_r   <= CW'(1);
                        end
                    end else begin
                        state_r <= STABLE_HI;
                    end
                end
                CONF_LO: begin
                    if (!s_s) begin
                        if (cnt_inc_s == DEB_LAST) begin
                            state_r <= STABLE_LO;
                            level_r <= 1'b0;
                            cnt_r   <= '0;
                        end else begin
                            cnt_r <= cnt_inc_s;
                        end
                    end else begin
                        state_r <= STABLE_HI;
                        cnt_r   <= '0;
                    end
                end
                default: begin
                    state_r <= STABLE_LO;
                    level_r <= 1'b0;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    // Hold counter: consecutive cycles the clean level has been high, saturating.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_r <= '0;
        end else if (!level_r) begin
            hold_r <= '0;
        end else if (hold_r != HOLD_MAX) begin
            hold_r <= hold_r + HW'(1);
        end else begin
            hold_r <= hold_r;
        end
    end

    assign level     = level_r;
    assign glitch    = glitch_s;
    assign stuck_hit = stuck_hit_s;

endmodule

module parking_sensor_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STUCK_CYCLES    = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       raw_a,
    input  logic       raw_b,
    input  logic       clr,
    output logic       a,
    output logic       b,
    output logic       fault_a,
    output logic       fault_b,
    output logic [7:0] glitch_count
);

    logic       level_a_s;
    logic       level_b_s;
    logic       glitch_a_s;
    logic       glitch_b_s;
    logic       stuck_a_s;
    logic       stuck_b_s;
    logic [1:0] glitch_inc_s;
    logic [8:0] glitch_sum_s;
    logic [7:0] glitch_next_s;
    logic [7:0] glitch_count_r;
    logic       fault_a_r;
    logic       fault_b_r;

    parking_sensor_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .STUCK_CYCLES   (STUCK_CYCLES)
    ) u_chan_a (
        .clk      (clk),
        .reset    (reset),
        .raw      (raw_a),
        .level    (level_a_s),
        .glitch   (glitch_a_s),
        .stuck_hit(stuck_a_s)
    );

    parking_sensor_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .STUCK_CYCLES   (STUCK_CYCLES)
    ) u_chan_b (
        .clk      (clk),
        .reset    (reset),
        .raw      (raw_b),
        .level    (level_b_s),
        .glitch   (glitch_b_s),
        .stuck_hit(stuck_b_s)
    );

    // Per-cycle glitch total (0..2) added to the running count, clamped at 255.
    always_comb begin
        glitch_inc_s = {1'b0, glitch_a_s} + {1'b0, glitch_b_s};
        glitch_sum_s = {1'b0, glitch_count_r} + {7'd0, glitch_inc_s};
        if (glitch_sum_s[8]) begin
            glitch_next_s = 8'hFF;
        end else begin
            glitch_next_s = glitch_sum_s[7:0];
        end
    end

    // Glitch counter; on clr only this cycle's glitches survive.
    always_ff @(posedge clk) begin
        if (reset) begin
            glitch_count_r <= 8'd0;
        end else if (clr) begin
            glitch_count_r <= {6'd0, glitch_inc_s};
        end else begin
            glitch_count_r <= glitch_next_s;
        end
    end

    // Sticky stuck-sensor flags; a fault arriving with clr still sets the flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            fault_a_r <= 1'b0;
            fault_b_r <= 1'b0;
        end else begin
            if (stuck_a_s) begin
                fault_a_r <= 1'b1;
            end else if (clr) begin
                fault_a_r <= 1'b0;
            end else begin
                fault_a_r <= fault_a_r;
            end
            if (stuck_b_s) begin
                fault_b_r <= 1'b1;
            end else if (clr) begin
                fault_b_r <= 1'b0;
            end else begin
                fault_b_r <= fault_b_r;
            end
        end
    end

    assign a            = level_a_s;
    assign b            = level_b_s;
    assign fault_a      = fault_a_r;
    assign fault_b      = fault_b_r;
    assign glitch_count = glitch_count_r;

endmodule

// File: doc/parking_sensor_conditioner.md
# parking_sensor_conditioner

Conditions the two raw beam-sensor inputs of the car-parking lot before they reach the entry/exit FSM. The block synchronises each raw sensor to `clk`, debounces it with a per-channel confirm state machine, and drives clean `a`/`b` levels straight into the parking FSM's `a`/`b` inputs. It also counts rejected glitches and flags a beam that stays blocked abnormally long, which indicates a stuck sensor.

## Interface

- `DEBOUNCE_CYCLES`, default 4: consecutive synchronised samples of a new level required before the output changes; legal range is 1..255.
- `STUCK_CYCLES`, default 1000: consecutive cycles of a clean output held high before the stuck fault is raised; legal range is 2..2^20-1.
- `clk`, input, 1: the single system clock; everything is rising-edge.
- `reset`, input, 1: synchronous, active-high; clears all state.
- `raw_a`, input, 1: outer beam sensor, asynchronous; 1 means the beam is blocked.
- `raw_b`, input, 1: inner beam sensor, asynchronous; 1 means the beam is blocked.
- `clr`, input, 1: synchronous; clears `glitch_count`, `fault_a` and `fault_b`.
- `a`, output, 1: debounced outer sensor; feeds the parking FSM `a`.
- `b`, output, 1: debounced inner sensor; feeds the parking FSM `b`.
- `fault_a`, output, 1: sticky stuck-blocked flag for channel a.
- `fault_b`, output, 1: sticky stuck-blocked flag for channel b.
- `glitch_count`, output, 8: total rejected glitches on both channels; saturates at 255.

## Operation

- **Per-channel path:** a 2-FF synchroniser produces `s`, which feeds the debounce FSM and a confirm counter of width ceil(log2(DEBOUNCE_CYCLES+1)).
- **Debounce FSM states:** STABLE_LO, CONF_HI, STABLE_HI, CONF_LO. The output is 0 in STABLE_LO and CONF_HI, and 1 in STABLE_HI and CONF_LO.
- **STABLE_LO:**
  - if `s`=1, load cnt=1.
  - If DEBOUNCE_CYCLES=1, go directly to STABLE_HI.
  - Otherwise go to CONF_HI.
- **CONF_HI:**
  - if `s`=1, increment cnt.
  - When the incremented cnt reaches DEBOUNCE_CYCLES, go to STABLE_HI and clear cnt.
  - if `s`=0, go to STABLE_LO, clear cnt, and register one glitch.
- **STABLE_HI / CONF_LO:** symmetric to the two cases above, with the polarities swapped.
- **Glitch counting:**
  - Each channel produces a per-cycle glitch pulse.
  - `glitch_count` adds 0, 1 or 2 per cycle, so simultaneous glitches on both channels add 2.
  - The count saturates at 255; it never wraps.
- **Stuck detection:**
  - Each channel has a hold counter of width ceil(log2(STUCK_CYCLES+1)).
  - The counter increments every cycle the output is 1 and clears whenever the output is 0.
  - It saturates at STUCK_CYCLES.
  - When it reaches STUCK_CYCLES, the fault flag sets and stays set until `clr` or `reset`, even after the beam clears.
  - A fault does not alter `a`/`b`; the FSM keeps seeing the real level.
- **`clr`:**
  - Clears `glitch_count` and both faults.
  - Does not affect the debounce FSMs, `a`/`b`, or the hold counters.
  - If `clr` and a new fault or glitch occur in the same cycle, the event wins: the flag ends at 1 and the count ends at the number of glitches in that cycle.
- **Channel independence:** the channels are fully independent, so simultaneous transitions on a and b commit on the same edge.

## Timing

- **Reset values:**
  - All synchroniser FFs = 0, FSMs = STABLE_LO, all counters = 0.
  - Outputs: `a`=0, `b`=0, `fault_a`=0, `fault_b`=0, `glitch_count`=0.
- **Reset timing:** `reset` takes effect at the first rising edge where it is sampled high; outputs hold their reset values while it stays high.
- **Reset mid-operation:** reset during a confirm sequence or a stuck count discards that sequence; no glitch is counted.
- **Latency:**
  - Edge 0 is the first edge at which a clean raw level change is sampled.
  - The output changes at edge DEBOUNCE_CYCLES+1. With the default of 4, that is edge 5.
- **Glitch rule:**
  - A raw pulse that yields fewer than DEBOUNCE_CYCLES synchronised samples never reaches `a`/`b`.
  - Its glitch increments `glitch_count` on the edge after its last sample.
- **Stuck timing:** the fault rises on the edge at which the output has been high for STUCK_CYCLES consecutive edges.
- **Output registration:** all outputs are registered, with no combinational path from any input to any output.

## Test plan

All scenarios use DEBOUNCE_CYCLES=4, STUCK_CYCLES=16, and assert `reset` for 2 cycles first.

1. **Clean edges:** set `raw_a` 0→1 for 10 cycles, then back to 0 → `a` rises at edge 5 after the change and falls 5 edges after release; `glitch_count` stays 0.
2. **Glitches:**
   - A 2-cycle pulse on `raw_b` → `b` stays 0 and `glitch_count`=1.
   - Simultaneous 3-cycle pulses on `raw_a` and `raw_b` → `glitch_count`=3.
3. **Saturation:** inject 260 glitches → `glitch_count` holds at 255; `clr` returns it to 0.
4. **Stuck sensor:**
   - Hold `raw_a`=1 for 30 cycles → `fault_a` rises when `a` has been high 16 edges; `a` remains 1.
   - Release `raw_a` → `fault_a` stays 1 until `clr`.
5. **Full car pass:** raw sequence a, ab, b, none, each held 8 cycles → `a`/`b` reproduce the sequence delayed by 5 edges, with no glitches.
6. **Reset mid-confirm:** assert `reset` 2 cycles after `raw_a` rises → `a`=0, `glitch_count`=0, and a fresh 5-edge latency applies after `reset` is released.
